jt12_mmr_q: RTL and testbench
=============================

# jt12_mmr_q

Buffered, multi-bank memory-mapped register front-end for the JT12 FM core. It accepts CPU address/data writes over a parametrised number of register banks and decodes global registers (timers, LFO, PCM) directly. Key-on and channel/operator register writes are pushed into a write queue. The queue drains to the downstream register-update engine over a valid/ready handshake, so the CPU sees `busy` only when the queue is full.

## Interface
Parameters:
- `BANKS`, 2, number of register banks (power of two, ≥2; 2 = 6 channels, 4 = 12 channels); `BW = log2(BANKS)`
- `DEPTH`, 8, write-queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `write`  in  1  per-cycle access strobe; each high cycle is one access
- `addr`  in  BW+1  `addr[0]`: 0 = address write, 1 = data write; `addr[BW:1]` = bank
- `din`  in  8  CPU data
- `dout`  out  8  status `{busy, 5'b0, flag_B, flag_A}`, combinational
- `busy`  out  1  queue full (registered)
- `wr_drop`  out  1  one-cycle pulse: write discarded because `busy`
- `flag_A`, `flag_B`  in  1  timer flags from the timer block
- `up_valid`  out  1  queue head valid
- `up_ready`  in  1  downstream accepts head
- `up_bank`  out  BW  head bank
- `up_reg`  out  8  head register number
- `up_data`  out  8  head data
- `value_A`  out  10  timer A period
- `value_B`  out  8  timer B period
- `load_A`, `load_B`, `clr_flag_A`, `clr_flag_B`  out  1  one-cycle pulses
- `enable_irq_A`, `enable_irq_B`  out  1  IRQ enables
- `csm`, `effect`  out  1  CH3 mode bits
- `lfo_en`  out  1  LFO enable; `lfo_freq`  out  3  LFO rate
- `pcm`  out  9  DAC sample; `pcm_en`  out  1  DAC enable

## Operation
- An access is processed only when `write` is high and `busy` is low. A `write` while `busy` is ignored and pulses `wr_drop` on the next cycle.
- Address write: `sel_reg <= din`, `sel_bank <= addr[BW:1]`.
- Data write, `sel_reg < 0x30`:
  - Accepted only if `sel_bank == 0`; otherwise ignored.
  - 0x22: `{lfo_en, lfo_freq} <= din[3:0]`.
  - 0x24: `value_A[9:2] <= din`; 0x25: `value_A[1:0] <= din[1:0]`.
  - 0x26: `value_B <= din`.
  - 0x27: `effect <= |din[7:6]`; `csm <= (din[7:6]==2'b10)`; `{enable_irq_B, enable_irq_A} <= din[3:2]`; pulses `load_B=din[1]`, `load_A=din[0]`, `clr_flag_B=din[5]`, `clr_flag_A=din[4]`.
  - 0x2A: `pcm[8:1] <= din`; 0x2B: `pcm_en <= din[7]`; 0x2C: `pcm[0] <= din[3]`.
  - 0x28 (key-on): pushed to the queue.
  - All other values are ignored.
- Data write, `sel_reg ≥ 0x30`: pushed to the queue as `{sel_bank, sel_reg, din}` if `sel_reg[1:0] != 2'b11`; otherwise ignored. This holds for every bank.
- Queue:
  - Show-ahead FIFO with `count` 0..DEPTH. `up_valid = (count != 0)`; `up_*` present the head entry.
  - Pop on `up_valid && up_ready`. Push and pop may occur in the same cycle; `count` is then unchanged.
  - `busy <= (next_count == DEPTH)`.
  - Read and write pointers wrap modulo DEPTH.
- `sel_reg` and `sel_bank` persist across data writes, so repeated data writes re-use the last address.

## Timing
- All outputs are registered except `dout` and `up_*`, which are driven directly from registers and the queue head.
- Global register data write sampled at edge n: the output reflects it after edge n.
- Pulse outputs are high for exactly one cycle, starting after edge n, and are cleared at edge n+1. Back-to-back 0x27 writes produce back-to-back pulses.
- Queue push at edge n: `up_valid` is high after edge n (1-cycle latency). A held `up_ready` drains one entry per cycle.
- Full boundary:
  - `busy` rises after the edge that makes `count == DEPTH`.
  - A write in that same cycle (while `busy` is still low) is the last accepted.
  - `busy` falls after the edge at which a pop leaves `count < DEPTH`.
- Empty boundary: `up_ready` while `up_valid` is low has no effect.
- Reset values: all outputs and internal state are 0; the queue is emptied (`up_valid = 0`, `busy = 0`); `sel_reg = 0x00`, `sel_bank = 0`.
- Reset asserted mid-operation discards queued entries immediately (asynchronous).

## Test plan
- Write addr 0x24/data 0xAB, then addr 0x25/data 0x03 (bank 0) -> `value_A = 0x2AF`. Bank-1 write of 0x26/0x55 -> `value_B` unchanged.
- Write 0x27/0x3F -> `load_A`, `load_B`, `clr_flag_A`, `clr_flag_B` high for exactly 1 cycle; `enable_irq_A = enable_irq_B = 1`; `effect = 0`, `csm = 0`. Write 0x27/0x80 -> `csm = 1`, `effect = 1`.
- `up_ready = 0`; bank 1, reg 0x41, then 9 data writes 0x00..0x08 (DEPTH=8):
  - `busy` rises after the 8th data write.
  - The 9th write is dropped with a `wr_drop` pulse.
  - Raising `up_ready` drains `{1, 0x41, 0x00}`..`{1, 0x41, 0x07}` in order, one per cycle.
- Register 0x33 data write -> no push. Register 0x28/0xF1 on bank 1 -> pushed as `{1, 0x28, 0xF1}`, because key-on bypasses the bank-0 rule.
- Queue holding 3 entries with `up_ready = 1` plus a simultaneous push -> `count` stays at 3 and the order is preserved. Assert `rst` mid-drain -> `up_valid = 0`, `busy = 0` immediately.

Source files
------------

// File: rtl/jt12_mmr_q.sv
// rtl/jt12_mmr_q.sv - JT12 buffered multi-bank register front-end with channel write queue
//
// jt12_mmr_q: CPU register interface for the JT12 FM core. Global registers
// (LFO, timers, PCM) are decoded here. Key-on and channel/operator writes are
// queued toward the register-update engine.
//   clk, rst            clock, asynchronous active-high reset
//   write, addr, din    CPU access strobe, {bank, data/address select}, data
//   dout, busy, wr_drop status byte, queue-full flag, dropped-write pulse
//   flag_A, flag_B      timer flags shown in dout
//   up_valid/ready      queue head handshake; up_bank/up_reg/up_data = head entry
//   value_A/B, load_*, clr_flag_*, enable_irq_*   timer control
//   csm, effect, lfo_en, lfo_freq, pcm, pcm_en    global mode outputs
//
// jt12_mmr_q_fifo: show-ahead FIFO used as the write queue.
//   push/wdata, ready   enqueue, and pop request from downstream
//   valid/head          head entry present / head entry contents
//   full                registered count==DEPTH flag

module jt12_mmr_q_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          pop;

    // Popping an empty queue is a no-op, so ready alone never moves the pointer.
    assign pop   = (count != '0) && ready;
    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + CW'(1);
        end else if (pop && !push) begin
            next_count = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= next_count;
            full  <= (next_count == CW'(DEPTH));
        end
    end
endmodule

module jt12_mmr_q #(
    parameter int BANKS = 2,
    parameter int DEPTH = 8,
    localparam int BW   = $clog2(BANKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic [BW:0]   addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          busy,
    output logic          wr_drop,
    input  logic          flag_A,
    input  logic          flag_B,
    output logic          up_valid,
    input  logic          up_ready,
    output logic [BW-1:0] up_bank,
    output logic [7:0]    up_reg,
    output logic [7:0]    up_data,
    output logic [9:0]    value_A,
    output logic [7:0]    value_B,
    output logic          load_A,
    output logic          load_B,
    output logic          clr_flag_A,
    output logic          clr_flag_B,
    output logic          enable_irq_A,
    output logic          enable_irq_B,
    output logic          csm,
    output logic          effect,
    output logic          lfo_en,
    output logic [2:0]    lfo_freq,
    output logic [8:0]    pcm,
    output logic          pcm_en
);
    logic [7:0]      sel_reg;
    logic [BW-1:0]   sel_bank;
    logic            accept;
    logic            data_wr;
    logic            queueable;
    logic            global_wr;
    logic            push;
    logic [BW+15:0]  head;

    assign accept = write && !busy;
    assign data_wr = accept && addr[0];

    // Key-on (0x28) is queued from any bank; operator/channel registers are
    // queued from any bank except the unused xx3 slots.
    assign queueable = (sel_reg == 8'h28) ||
                       ((sel_reg >= 8'h30) && (sel_reg[1:0] != 2'b11));
    assign push      = data_wr && queueable;
    assign global_wr = data_wr && (sel_reg < 8'h30) && (sel_bank == '0);

    assign dout = {busy, 5'b0, flag_B, flag_A};

    jt12_mmr_q_fifo #(
        .W     (BW + 16),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({sel_bank, sel_reg, din}),
        .ready (up_ready),
        .valid (up_valid),
        .head  (head),
        .full  (busy)
    );

    assign up_bank = head[BW+15:16];
    assign up_reg  = head[15:8];
    assign up_data = head[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg      <= 8'h00;
            sel_bank     <= '0;
            wr_drop      <= 1'b0;
            value_A      <= 10'd0;
            value_B      <= 8'd0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            csm          <= 1'b0;
            effect       <= 1'b0;
            lfo_en       <= 1'b0;
            lfo_freq     <= 3'd0;
            pcm          <= 9'd0;
            pcm_en       <= 1'b0;
        end else begin
            // Strobes last one cycle unless another 0x27 write re-arms them.
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            wr_drop    <= write && busy;

            if (accept && !addr[0]) begin
                sel_reg  <= din;
                sel_bank <= addr[BW:1];
            end

            if (global_wr) begin
                case (sel_reg)
                    8'h22: {lfo_en, lfo_freq} <= din[3:0];
                    8'h24: value_A[9:2] <= din;
                    8'h25: value_A[1:0] <= din[1:0];
                    8'h26: value_B <= din;
                    8'h27: begin
                        effect       <= |din[7:6];
                        csm          <= (din[7:6] == 2'b10);
                        enable_irq_B <= din[3];
                        enable_irq_A <= din[2];
                        load_B       <= din[1];
                        load_A       <= din[0];
                        clr_flag_B   <= din[5];
                        clr_flag_A   <= din[4];
                    end
                    8'h2A: pcm[8:1] <= din;
                    8'h2B: pcm_en <= din[7];
                    8'h2C: pcm[0] <= din[3];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jt12_mmr_q.sv
// tb/tb_jt12_mmr_q.sv - directed and randomized bench for jt12_mmr_q against a queue-based model

module tb_jt12_mmr_q;
    localparam int BANKS = 2;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write = 1'b0;
    logic [1:0] addr = 2'b0;
    logic [7:0] din = 8'h0;
    logic [7:0] dout;
    logic       busy, wr_drop;
    logic       flag_A = 1'b0, flag_B = 1'b0;
    logic       up_valid;
    logic       up_ready = 1'b0;
    logic [0:0] up_bank;
    logic [7:0] up_reg, up_data;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_flag_A, clr_flag_B;
    logic       enable_irq_A, enable_irq_B, csm, effect, lfo_en;
    logic [2:0] lfo_freq;
    logic [8:0] pcm;
    logic       pcm_en;

    jt12_mmr_q #(.BANKS(BANKS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .write(write), .addr(addr), .din(din),
        .dout(dout), .busy(busy), .wr_drop(wr_drop),
        .flag_A(flag_A), .flag_B(flag_B),
        .up_valid(up_valid), .up_ready(up_ready), .up_bank(up_bank),
        .up_reg(up_reg), .up_data(up_data),
        .value_A(value_A), .value_B(value_B),
        .load_A(load_A), .load_B(load_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .csm(csm), .effect(effect), .lfo_en(lfo_en), .lfo_freq(lfo_freq),
        .pcm(pcm), .pcm_en(pcm_en)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [9:0]  m_value_A;
    logic [7:0]  m_value_B;
    logic        m_lfo_en;
    logic [2:0]  m_lfo_freq;
    logic [8:0]  m_pcm;
    logic        m_pcm_en, m_irq_A, m_irq_B, m_csm, m_effect;
    logic [3:0]  m_pulse;   // {load_A, load_B, clr_flag_A, clr_flag_B}
    logic        m_busy, m_drop;
    logic [7:0]  m_sel_reg;
    logic        m_sel_bank;
    logic [16:0] m_q[$];
    logic        rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_value_A = 0; m_value_B = 0; m_lfo_en = 0; m_lfo_freq = 0;
        m_pcm = 0; m_pcm_en = 0; m_irq_A = 0; m_irq_B = 0; m_csm = 0; m_effect = 0;
        m_pulse = 0; m_busy = 0; m_drop = 0; m_sel_reg = 0; m_sel_bank = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic w, input logic [1:0] a, input logic [7:0] d, input logic r);
        bit do_pop;
        do_pop  = (m_q.size() != 0) && r;
        m_pulse = 4'b0;
        m_drop  = w && m_busy;
        if (w && !m_busy) begin
            if (!a[0]) begin
                m_sel_reg  = d;
                m_sel_bank = a[1];
            end else if (m_sel_reg == 8'h28 || (m_sel_reg >= 8'h30 && (m_sel_reg % 4) != 3)) begin
                m_q.push_back({m_sel_bank, m_sel_reg, d});
            end else if (m_sel_reg < 8'h30 && m_sel_bank == 1'b0) begin
                case (m_sel_reg)
                    8'h22: begin m_lfo_en = d[3]; m_lfo_freq = d[2:0]; end
                    8'h24: m_value_A = {d, m_value_A[1:0]};
                    8'h25: m_value_A = {m_value_A[9:2], d[1:0]};
                    8'h26: m_value_B = d;
                    8'h27: begin
                        m_effect = (d[7:6] != 0);
                        m_csm    = (d[7:6] == 2);
                        m_irq_B  = d[3];
                        m_irq_A  = d[2];
                        m_pulse  = {d[0], d[1], d[4], d[5]};
                    end
                    8'h2A: m_pcm = {d, m_pcm[0]};
                    8'h2B: m_pcm_en = d[7];
                    8'h2C: m_pcm = {m_pcm[8:1], d[3]};
                    default: ;
                endcase
            end
        end
        if (do_pop) void'(m_q.pop_front());
        m_busy = (m_q.size() == DEPTH);
    endtask

    task automatic check_all();
        chk("timers", {value_A, value_B}, {m_value_A, m_value_B});
        chk("modes", {lfo_en, lfo_freq, pcm, pcm_en, enable_irq_A, enable_irq_B, csm, effect},
            {m_lfo_en, m_lfo_freq, m_pcm, m_pcm_en, m_irq_A, m_irq_B, m_csm, m_effect});
        chk("pulses", {load_A, load_B, clr_flag_A, clr_flag_B}, m_pulse);
        chk("busy", busy, m_busy);
        chk("wr_drop", wr_drop, m_drop);
        chk("up_valid", up_valid, m_q.size() != 0);
        chk("dout", dout, {m_busy, 5'b0, flag_B, flag_A});
        if (m_q.size() != 0) chk("head", {up_bank, up_reg, up_data}, m_q[0]);
    endtask

    task automatic cycle(input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        write = w; addr = a; din = d; up_ready = rdy;
        flag_A = 1'($urandom); flag_B = 1'($urandom);
        @(posedge clk);
        model_step(w, a, d, rdy);
        #1;
        check_all();
    endtask

    task automatic wr_addr(input logic bank, input logic [7:0] r);
        cycle(1'b1, {bank, 1'b0}, r);
    endtask

    task automatic wr_data(input logic bank, input logic [7:0] d);
        cycle(1'b1, {bank, 1'b1}, d);
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 8'h00);
    endtask

    logic [7:0] reg_pick [10] = '{8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h2A, 8'h2B, 8'h2C, 8'h21};

    initial begin
        // Reset state
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Timer A/B values and bank-1 global write ignored
        wr_addr(0, 8'h24); wr_data(0, 8'hAB);
        wr_addr(0, 8'h25); wr_data(0, 8'h03);
        chk("value_A_2AF", value_A, 10'h2AF);
        wr_addr(1, 8'h26); wr_data(1, 8'h55);
        chk("value_B_bank1", value_B, 8'h00);

        // 0x27 pulses and mode bits
        wr_addr(0, 8'h27); wr_data(0, 8'h3F);
        chk("pulses_3F", {load_A, load_B, clr_flag_A, clr_flag_B}, 4'hF);
        idle();
        chk("pulses_clear", {load_A, load_B, clr_flag_A, clr_flag_B}, 4'h0);
        wr_data(0, 8'h80);
        chk("csm_effect", {csm, effect}, 2'b11);
        wr_data(0, 8'h01);
        wr_data(0, 8'h01);
        chk("load_A_b2b", load_A, 1'b1);
        idle();

        // Fill to full with up_ready low, then drain in order
        rdy = 1'b0;
        wr_addr(1, 8'h41);
        for (int i = 0; i < 8; i++) wr_data(1, 8'(i));
        chk("busy_full", busy, 1'b1);
        wr_data(1, 8'h08);
        chk("wr_drop_9th", wr_drop, 1'b1);
        idle();
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", {up_bank, up_reg, up_data}, {1'b1, 8'h41, 8'(i)});
            idle();
        end
        chk("drained", up_valid, 1'b0);

        // 0x33 not queued; key-on from bank 1 is queued
        rdy = 1'b0;
        wr_addr(0, 8'h33); wr_data(0, 8'h11);
        chk("reg33_nopush", up_valid, 1'b0);
        wr_addr(1, 8'h28); wr_data(1, 8'hF1);
        chk("keyon_bank1", {up_valid, up_bank, up_reg, up_data}, {1'b1, 1'b1, 8'h28, 8'hF1});
        rdy = 1'b1;
        idle();

        // Simultaneous push and pop with three entries, then async reset mid-drain
        rdy = 1'b0;
        wr_addr(0, 8'h30);
        wr_data(0, 8'hA1); wr_data(0, 8'hA2); wr_data(0, 8'hA3);
        rdy = 1'b1;
        wr_data(0, 8'hA4);
        chk("pushpop_head", {up_bank, up_reg, up_data}, {1'b0, 8'h30, 8'hA2});
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_up_valid", up_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with varying downstream back-pressure
        for (int blk = 0; blk < 15; blk++) begin
            int thr;
            thr = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 200; i++) begin
                logic [7:0] r;
                logic       bank;
                rdy  = ($urandom_range(0, 99) < thr);
                bank = 1'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    r = ($urandom_range(0, 2) == 0) ? reg_pick[$urandom_range(0, 9)]
                                                    : 8'($urandom_range(8'h30, 8'hFF));
                    wr_addr(bank, r);
                end else if ($urandom_range(0, 4) != 0) begin
                    wr_data(bank, 8'($urandom));
                end else begin
                    idle();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
